div_sequencer: RTL

- Iterative divide controller and datapath for the MDU division path of the EX-stage executor.
- Accepts RV32M DIV/DIVU/REM/REMU operands and runs a radix-2 restoring division, one quotient bit per cycle.
- Raises a finished flag that the executor uses to release its MDU bubble.
- Honours the MA-stage stall and the pipeline flush.

---
 rtl/div_sequencer_if.sv | 39 +++
 rtl/div_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Operand, control and result bundle between the EX-stage executor and the divider.
// The executor drives the master side; div_sequencer sits on the slave side.
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            s_start_i;
    logic [1:0]      s_op_i;
    logic [XLEN-1:0] s_dividend_i;
    logic [XLEN-1:0] s_divisor_i;
    logic            s_stall_i;
    logic            s_flush_i;
    logic            s_busy_o;
    logic            s_finished_o;
    logic [XLEN-1:0] s_result_o;

    modport slave (
        input  s_start_i,
        input  s_op_i,
        input  s_dividend_i,
        input  s_divisor_i,
        input  s_stall_i,
        input  s_flush_i,
        output s_busy_o,
        output s_finished_o,
        output s_result_o
    );

    modport master (
        output s_start_i,
        output s_op_i,
        output s_dividend_i,
        output s_divisor_i,
        output s_stall_i,
        output s_flush_i,
        input  s_busy_o,
        input  s_finished_o,
        input  s_result_o
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_EXIT_EN skips the leading-zero iterations of the dividend.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic            s_clk_i,
    input logic            s_rst_i,
    div_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_CALC = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b100;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(XLEN - 1);

    // Magnitude of an operand; unsigned ops pass through untouched.
    function automatic logic [XLEN-1:0] f_abs(input logic signed [XLEN-1:0] v,
                                              input logic                   is_signed);
        logic signed [XLEN-1:0] neg;
        neg = -v;
        return (is_signed && v[XLEN-1]) ? neg : v;
    endfunction

    function automatic logic [XLEN-1:0] f_apply_sign(input logic [XLEN-1:0] mag,
                                                     input logic            neg);
        logic signed [XLEN-1:0] smag;
        smag = mag;
        return neg ? -smag : smag;
    endfunction

`ifdef DIV_EARLY_EXIT_EN
    // Index of the highest set bit, i.e. XLEN-1 minus the leading-zero count.
    function automatic logic [CNT_W-1:0] f_top_bit(input logic [XLEN-1:0] v);
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) idx = CNT_W'(i);
        end
        return idx;
    endfunction
`endif

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_special;
    logic [XLEN-1:0]  r_dvd;
    logic [XLEN-1:0]  r_dsr;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_rem;

    logic             w_is_idle;
    logic             w_is_calc;
    logic             w_is_done;
    logic             w_op_signed;
    logic             w_launch;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_dvd_zero;
    logic [XLEN-1:0]  w_dvd_mag;
    logic [XLEN-1:0]  w_dsr_mag;
    logic [CNT_W-1:0] w_cnt_init;
    logic [XLEN:0]    w_rem_shift;
    logic             w_rem_ge;
    logic [XLEN-1:0]  w_rem_next;
    logic [XLEN-1:0]  w_quot_out;
    logic [XLEN-1:0]  w_rem_out;

    // Full-width compares so a corrupted state vector never decodes as two states.
    assign w_is_idle = (r_state == ST_IDLE);
    assign w_is_calc = (r_state == ST_CALC);
    assign w_is_done = (r_state == ST_DONE);

    assign w_op_signed = ~bus.s_op_i[0];
    assign w_launch    = bus.s_start_i & ~bus.s_flush_i;
    assign w_dvd_mag   = f_abs(bus.s_dividend_i, w_op_signed);
    assign w_dsr_mag   = f_abs(bus.s_divisor_i, w_op_signed);
    assign w_div_zero  = (bus.s_divisor_i == '0);
    assign w_overflow  = w_op_signed && (bus.s_dividend_i == MIN_NEG)
                                     && (bus.s_divisor_i == ALL_ONES);

`ifdef DIV_EARLY_EXIT_EN
    assign w_dvd_zero = (w_dvd_mag == '0);
    assign w_cnt_init = f_top_bit(w_dvd_mag);
`else
    assign w_dvd_zero = 1'b0;
    assign w_cnt_init = CNT_TOP;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_rem_shift = {r_rem, r_dvd[r_cnt]};
        w_rem_ge    = (w_rem_shift >= {1'b0, r_dsr});
        w_rem_next  = w_rem_shift[XLEN-1:0];
        if (w_rem_ge) begin
            w_rem_next = XLEN'(w_rem_shift - {1'b0, r_dsr});
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_special <= 1'b0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
        end else if (bus.s_flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_op      <= bus.s_op_i;
                        r_sign_q  <= bus.s_dividend_i[XLEN-1] ^ bus.s_divisor_i[XLEN-1];
                        r_sign_r  <= bus.s_dividend_i[XLEN-1];
                        r_dvd     <= w_dvd_mag;
                        r_dsr     <= w_dsr_mag;
                        r_special <= 1'b0;
                        r_quot    <= '0;
                        r_rem     <= '0;
                        r_cnt     <= w_cnt_init;
                        if (w_div_zero) begin
                            r_quot    <= ALL_ONES;
                            r_rem     <= bus.s_dividend_i;
                            r_special <= 1'b1;
                            r_state   <= ST_DONE;
                        end else if (w_overflow) begin
                            r_quot    <= MIN_NEG;
                            r_special <= 1'b1;
                            r_state   <= ST_DONE;
                        end else if (w_dvd_zero) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem         <= w_rem_next;
                    r_quot[r_cnt] <= w_rem_ge;
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Hold the result while MA cannot take it; leaving is the consume cycle.
                    if (!bus.s_stall_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Special-case results were loaded already signed-correct and bypass negation.
    always_comb begin
        w_quot_out = r_quot;
        w_rem_out  = r_rem;
        if (!r_special && !r_op[0]) begin
            w_quot_out = f_apply_sign(r_quot, r_sign_q);
            w_rem_out  = f_apply_sign(r_rem, r_sign_r);
        end
    end

    assign bus.s_busy_o     = ~w_is_idle;
    assign bus.s_finished_o = w_is_done & ~w_is_calc;
    assign bus.s_result_o   = w_is_done ? (r_op[1] ? w_rem_out : w_quot_out) : '0;

endmodule
